// File: rtl/l1cache_assoc_if.sv
// CPU request/response and MMU line-transfer signals of the L1 cache.
// "slave" is the cache's view; "master" is the CPU/MMU environment's view.
interface l1cache_assoc_if #(
  parameter int LINE_W = 256
);
  logic              l1_read;
  logic              l1_write;
  logic [31:0]       l1_addr;
  logic [1:0]        l1_write_type;
  logic [31:0]       l1_write_data;
  logic [31:0]       l1_data_o;
  logic              stall;
  logic              l1_mmu_req_read;
  logic              l1_mmu_req_write;
  logic [31:0]       l1_mmu_req_addr;
  logic [LINE_W-1:0] l1_mmu_write_data;
  logic              mmu_l1_read_done;
  logic              mmu_l1_write_done;
  logic [LINE_W-1:0] mmu_l1_read_data;

  modport slave (
    input  l1_read, l1_write, l1_addr, l1_write_type, l1_write_data,
    input  mmu_l1_read_done, mmu_l1_write_done, mmu_l1_read_data,
    output l1_data_o, stall,
    output l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data
  );

  modport master (
    output l1_read, l1_write, l1_addr, l1_write_type, l1_write_data,
    output mmu_l1_read_done, mmu_l1_write_done, mmu_l1_read_data,
    input  l1_data_o, stall,
    input  l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data
  );
endinterface

// File: rtl/l1cache_assoc.sv
// Set-associative write-back / write-allocate L1 data cache with age-based LRU.
// Hits complete combinationally; misses go IDLE -> (WB) -> FILL -> IDLE and
// the held request then hits on the cycle after the fill is installed.
module l1cache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 8
) (
  input logic           sys_clk,
  input logic           rst,
  l1cache_assoc_if.slave bus
);
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int OFF    = $clog2(LINE_WORDS) + 2;
  localparam int IW     = $clog2(SETS);
  localparam int TW     = 32 - OFF - IW;
  localparam int WSW    = $clog2(LINE_WORDS);
  localparam int WW     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_FILL = 2'd2} state_t;

  state_t state_q, state_d;

  logic              valid_q [WAYS][SETS];
  logic              dirty_q [WAYS][SETS];
  logic [WW-1:0]     age_q   [WAYS][SETS];
  logic [TW-1:0]     tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] line_q  [WAYS][SETS];

  logic [WW-1:0]     victim_q, victim_d;
  logic              req_read_q, req_read_d;
  logic              req_write_q, req_write_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic [IW-1:0]  idx_s;
  logic [TW-1:0]  tag_s;
  logic [WSW-1:0] wsel_s;
  logic           req_s, hit_s, hit_acc_s, install_s, victim_dirty_s;
  logic           inv_found_s;
  logic [WW-1:0]  hit_way_s, inv_way_s, old_way_s, victim_s, acc_way_s;
  logic [WW-1:0]  old_age_s;
  logic [WW-1:0]  age_nx_s [WAYS];
  logic [31:0]    rd_word_s;

  // Merge a word/half/byte store into a cached line; type 11 behaves as word.
  function automatic logic [LINE_W-1:0] merge_store(
    input logic [LINE_W-1:0] line,
    input logic [WSW-1:0]    wsel,
    input logic [1:0]        wtype,
    input logic [1:0]        bsel,
    input logic [31:0]       wdata
  );
    logic [LINE_W-1:0] res;
    logic [31:0]       word;
    res  = line;
    word = line[int'(wsel) * 32 +: 32];
    case (wtype)
      2'b01: begin
        if (bsel[1]) word[31:16] = wdata[15:0];
        else         word[15:0]  = wdata[15:0];
      end
      2'b10:   word[int'(bsel) * 8 +: 8] = wdata[7:0];
      default: word = wdata;
    endcase
    res[int'(wsel) * 32 +: 32] = word;
    return res;
  endfunction

  assign idx_s     = bus.l1_addr[OFF +: IW];
  assign tag_s     = bus.l1_addr[OFF + IW +: TW];
  assign wsel_s    = bus.l1_addr[OFF-1:2];
  assign req_s     = bus.l1_read | bus.l1_write;
  assign hit_acc_s = (state_q == S_IDLE) & req_s & hit_s;
  assign install_s = (state_q == S_FILL) & bus.mmu_l1_read_done;

  // Tag lookup across the ways of the indexed set (lowest matching way wins).
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = {WW{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      hit_way_s = (valid_q[w][idx_s] && (tag_q[w][idx_s] == tag_s) && !hit_s) ? WW'(w) : hit_way_s;
      hit_s     = hit_s | (valid_q[w][idx_s] && (tag_q[w][idx_s] == tag_s));
    end
  end

  // Victim choice: lowest invalid way, otherwise the oldest (age WAYS-1) way.
  always_comb begin
    inv_found_s = 1'b0;
    inv_way_s   = {WW{1'b0}};
    old_way_s   = {WW{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      inv_way_s   = (!valid_q[w][idx_s] && !inv_found_s) ? WW'(w) : inv_way_s;
      inv_found_s = inv_found_s | !valid_q[w][idx_s];
      old_way_s   = (age_q[w][idx_s] == WW'(WAYS - 1)) ? WW'(w) : old_way_s;
    end
    victim_s       = inv_found_s ? inv_way_s : old_way_s;
    victim_dirty_s = valid_q[victim_s][idx_s] & dirty_q[victim_s][idx_s];
  end

  // LRU ages after touching acc_way: it becomes 0, younger ways age by one.
  always_comb begin
    acc_way_s = (state_q == S_FILL) ? victim_q : hit_way_s;
    old_age_s = age_q[acc_way_s][idx_s];
    for (int w = 0; w < WAYS; w++) begin
      age_nx_s[w] = (WW'(w) == acc_way_s) ? {WW{1'b0}} :
                    ((age_q[w][idx_s] < old_age_s) ? age_q[w][idx_s] + WW'(1) : age_q[w][idx_s]);
    end
  end

  // Line state bits: clear on reset, set on install, mark dirty and age on hits.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          age_q[w][s]   <= WW'(w);
        end
      end
    end else if (install_s) begin
      valid_q[victim_q][idx_s] <= 1'b1;
      dirty_q[victim_q][idx_s] <= 1'b0;
      for (int w = 0; w < WAYS; w++) age_q[w][idx_s] <= age_nx_s[w];
    end else if (hit_acc_s) begin
      dirty_q[hit_way_s][idx_s] <= dirty_q[hit_way_s][idx_s] | bus.l1_write;
      for (int w = 0; w < WAYS; w++) age_q[w][idx_s] <= age_nx_s[w];
    end
  end

  // Tag and data arrays: written by fills and by store hits; no reset needed.
  always_ff @(posedge sys_clk) begin
    if (install_s) begin
      tag_q[victim_q][idx_s]  <= tag_s;
      line_q[victim_q][idx_s] <= bus.mmu_l1_read_data;
    end else if (hit_acc_s && bus.l1_write) begin
      line_q[hit_way_s][idx_s] <= merge_store(line_q[hit_way_s][idx_s], wsel_s,
                                              bus.l1_write_type, bus.l1_addr[1:0],
                                              bus.l1_write_data);
    end
  end

  // Miss FSM state register.
  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Miss FSM next state; done inputs only matter in their own state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_s && !hit_s) state_d = victim_dirty_s ? S_WB : S_FILL;
        else                 state_d = S_IDLE;
      end
      S_WB: begin
        if (bus.mmu_l1_write_done) state_d = S_FILL;
        else                       state_d = S_WB;
      end
      S_FILL: begin
        if (bus.mmu_l1_read_done) state_d = S_IDLE;
        else                      state_d = S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MMU request values for the next cycle, derived from the next state.
  always_comb begin
    req_read_d  = 1'b0;
    req_write_d = 1'b0;
    req_addr_d  = 32'h0;
    wdata_d     = {LINE_W{1'b0}};
    if (state_q == S_IDLE) victim_d = victim_s;
    else                   victim_d = victim_q;
    case (state_d)
      S_WB: begin
        req_write_d = 1'b1;
        req_addr_d  = {tag_q[victim_d][idx_s], idx_s, {OFF{1'b0}}};
        wdata_d     = line_q[victim_d][idx_s];
      end
      S_FILL: begin
        req_read_d = 1'b1;
        req_addr_d = {tag_s, idx_s, {OFF{1'b0}}};
      end
      default: begin
        req_read_d  = 1'b0;
        req_write_d = 1'b0;
      end
    endcase
  end

  // Registered MMU-side outputs and the latched victim way.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      victim_q    <= {WW{1'b0}};
      req_read_q  <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= 32'h0;
      wdata_q     <= {LINE_W{1'b0}};
    end else begin
      victim_q    <= victim_d;
      req_read_q  <= req_read_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign rd_word_s             = line_q[hit_way_s][idx_s][int'(wsel_s) * 32 +: 32];
  assign bus.stall             = ~rst & req_s & ~hit_acc_s;
  assign bus.l1_data_o         = (~rst & hit_acc_s & bus.l1_read & ~bus.l1_write) ? rd_word_s : 32'h0;
  assign bus.l1_mmu_req_read   = req_read_q;
  assign bus.l1_mmu_req_write  = req_write_q;
  assign bus.l1_mmu_req_addr   = req_addr_q;
  assign bus.l1_mmu_write_data = wdata_q;
endmodule

// File: tb/tb_l1cache_assoc.sv
// Directed bench for l1cache_assoc (2 ways, 16 sets, 8-word lines) with a
// behavioural MMU that answers each request after mmu_delay cycles.
module tb_l1cache_assoc;
  localparam int LINE_W = 256;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  l1cache_assoc_if #(.LINE_W(LINE_W)) bus ();

  l1cache_assoc #(.WAYS(2), .SETS(16), .LINE_WORDS(8)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int mmu_delay = 3;
  int mmu_cnt = 0;
  int wb_count = 0;
  int both_req = 0;
  int ncyc;
  logic [31:0] rdata;
  logic [31:0] last_wb_addr = 32'h0;
  logic [LINE_W-1:0] last_wb_data = '0;
  logic [LINE_W-1:0] mem [bit [31:0]];

  // Backing store: written-back lines, else a fixed pattern per line address.
  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    logic [3:0] k4;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++) begin
      k4 = 4'(k);
      l[k*32 +: 32] = (a == 32'h0) ? {8{k4}} : {a[15:0], 12'h000, k4};
    end
    return l;
  endfunction

  // MMU model: count request cycles, pulse done for one cycle at mmu_delay.
  always @(negedge sys_clk) begin
    if (bus.l1_mmu_req_read && bus.l1_mmu_req_write) both_req = both_req + 1;
    bus.mmu_l1_read_done  = 1'b0;
    bus.mmu_l1_write_done = 1'b0;
    if (rst) begin
      mmu_cnt = 0;
      bus.mmu_l1_read_data = '0;
    end else if (bus.l1_mmu_req_write) begin
      mmu_cnt = mmu_cnt + 1;
      if (mmu_cnt >= mmu_delay) begin
        bus.mmu_l1_write_done = 1'b1;
        last_wb_addr = bus.l1_mmu_req_addr;
        last_wb_data = bus.l1_mmu_write_data;
        mem[bus.l1_mmu_req_addr] = bus.l1_mmu_write_data;
        wb_count = wb_count + 1;
        mmu_cnt = 0;
      end
    end else if (bus.l1_mmu_req_read) begin
      mmu_cnt = mmu_cnt + 1;
      if (mmu_cnt >= mmu_delay) begin
        bus.mmu_l1_read_done = 1'b1;
        bus.mmu_l1_read_data = mem_line(bus.l1_mmu_req_addr);
        mmu_cnt = 0;
      end
    end else begin
      mmu_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access: drive, wait (bounded) for stall low, capture data, release.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [1:0] wt,
                        input logic [31:0] wd, output int cyc, output logic [31:0] data);
    bus.l1_read       = !wr;
    bus.l1_write      = wr;
    bus.l1_addr       = addr;
    bus.l1_write_type = wt;
    bus.l1_write_data = wd;
    cyc = 0;
    #1;
    while (bus.stall && cyc < 200) begin
      @(negedge sys_clk); #1;
      cyc++;
    end
    data = bus.l1_data_o;
    @(negedge sys_clk); #1;
    bus.l1_read  = 1'b0;
    bus.l1_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input int exp_cyc, input logic [31:0] exp_data);
    int c;
    logic [31:0] d;
    access(1'b0, addr, 2'b00, 32'h0, c, d);
    chk({tag, "_cycles"}, 32'(c), 32'(exp_cyc));
    chk({tag, "_data"}, d, exp_data);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [1:0] wt,
                    input logic [31:0] wd, input int exp_cyc);
    int c;
    logic [31:0] d;
    access(1'b1, addr, wt, wd, c, d);
    chk({tag, "_cycles"}, 32'(c), 32'(exp_cyc));
    chk({tag, "_data0"}, d, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.l1_read = 1'b0;
    bus.l1_write = 1'b0;
    bus.l1_addr = 32'h0;
    bus.l1_write_type = 2'b00;
    bus.l1_write_data = 32'h0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_data", bus.l1_data_o, 32'h0);
    chk("rst_req_read", 32'(bus.l1_mmu_req_read), 32'h0);
    chk("rst_req_write", 32'(bus.l1_mmu_req_write), 32'h0);
    chk("rst_req_addr", bus.l1_mmu_req_addr, 32'h0);
    chk("rst_wdata_lo", bus.l1_mmu_write_data[31:0], 32'h0);
    chk("rst_wdata_hi", bus.l1_mmu_write_data[255:224], 32'h0);
    rst = 1'b0;
    @(negedge sys_clk); #1;

    // Cold read miss into a clean set.
    bus.l1_addr = 32'h0000_000C;
    bus.l1_read = 1'b1;
    #1;
    chk("cold_stall", 32'(bus.stall), 32'h1);
    @(negedge sys_clk); #1;
    ncyc = 1;
    chk("cold_req_read", 32'(bus.l1_mmu_req_read), 32'h1);
    chk("cold_req_write", 32'(bus.l1_mmu_req_write), 32'h0);
    chk("cold_req_addr", bus.l1_mmu_req_addr, 32'h0);
    while (bus.stall && ncyc < 200) begin
      @(negedge sys_clk); #1;
      ncyc++;
    end
    chk("cold_cycles", 32'(ncyc), 32'd4);
    chk("cold_data", bus.l1_data_o, 32'h3333_3333);
    @(negedge sys_clk); #1;
    bus.l1_read = 1'b0;

    // Two tags in one set share the two ways without write-back.
    rd("t2_rd000", 32'h0000_0000, 0, 32'h0000_0000);
    rd("t2_rd200", 32'h0000_0200, 4, 32'h0200_0000);
    rd("t2_re000", 32'h0000_0000, 0, 32'h0000_0000);
    rd("t2_re204", 32'h0000_0204, 0, 32'h0200_0001);
    chk("t2_no_wb", 32'(wb_count), 32'h0);

    // Dirty line survives one clean eviction, then is written back.
    wr("t3_sw00c", 32'h0000_000C, 2'b00, 32'hAAAA_BBBB, 0);
    rd("t3_rd400", 32'h0000_0400, 4, 32'h0400_0000);
    chk("t3_no_wb", 32'(wb_count), 32'h0);
    rd("t3_rd600", 32'h0000_0600, 7, 32'h0600_0000);
    chk("t3_wb_count", 32'(wb_count), 32'h1);
    chk("t3_wb_addr", last_wb_addr, 32'h0);
    chk("t3_wb_w3", last_wb_data[3*32 +: 32], 32'hAAAA_BBBB);
    chk("t3_wb_w0", last_wb_data[0 +: 32], 32'h0000_0000);
    chk("t3_wb_w2", last_wb_data[2*32 +: 32], 32'h2222_2222);

    // Half/byte merges into the refetched line.
    rd("t4_rd000", 32'h0000_0000, 4, 32'h0000_0000);
    rd("t4_rd00c", 32'h0000_000C, 0, 32'hAAAA_BBBB);
    wr("t4_sh002", 32'h0000_0002, 2'b01, 32'hDEAD_1234, 0);
    wr("t4_sb009", 32'h0000_0009, 2'b10, 32'h1234_56FF, 0);
    wr("t4_sh010", 32'h0000_0010, 2'b01, 32'hBEEF_5678, 0);
    wr("t4_sb013", 32'h0000_0013, 2'b10, 32'h0000_00A5, 0);
    rd("t4_rd000m", 32'h0000_0000, 0, 32'h1234_0000);
    rd("t4_rd008m", 32'h0000_0008, 0, 32'h2222_FF22);
    rd("t4_rd004", 32'h0000_0004, 0, 32'h1111_1111);
    rd("t4_rd010m", 32'h0000_0010, 0, 32'hA544_5678);
    rd("t4_rd00cm", 32'h0000_000C, 0, 32'hAAAA_BBBB);

    // Slow MMU: request held stable while done stays low.
    mmu_delay = 13;
    bus.l1_addr = 32'h0000_0024;
    bus.l1_read = 1'b1;
    ncyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk); #1;
      ncyc++;
      chk("t5_stall", 32'(bus.stall), 32'h1);
      chk("t5_req_read", 32'(bus.l1_mmu_req_read), 32'h1);
      chk("t5_req_addr", bus.l1_mmu_req_addr, 32'h0000_0020);
    end
    while (bus.stall && ncyc < 200) begin
      @(negedge sys_clk); #1;
      ncyc++;
    end
    chk("t5_cycles", 32'(ncyc), 32'd14);
    chk("t5_data", bus.l1_data_o, 32'h0020_0001);
    @(negedge sys_clk); #1;
    bus.l1_read = 1'b0;

    // Reset in the middle of a fill abandons it and drops dirty data.
    mmu_delay = 1000;
    bus.l1_addr = 32'h0000_0048;
    bus.l1_read = 1'b1;
    repeat (2) @(negedge sys_clk);
    #1;
    chk("t6_req_before", 32'(bus.l1_mmu_req_read), 32'h1);
    chk("t6_addr_before", bus.l1_mmu_req_addr, 32'h0000_0040);
    rst = 1'b1;
    @(negedge sys_clk); #1;
    chk("t6_req_after", 32'(bus.l1_mmu_req_read), 32'h0);
    chk("t6_stall_after", 32'(bus.stall), 32'h0);
    chk("t6_addr_after", bus.l1_mmu_req_addr, 32'h0);
    rst = 1'b0;
    bus.l1_read = 1'b0;
    @(negedge sys_clk); #1;
    chk("t6_stall_idle", 32'(bus.stall), 32'h0);
    mmu_delay = 3;
    rd("t6_reread", 32'h0000_0048, 4, 32'h0040_0002);
    rd("t6_lost", 32'h0000_0000, 4, 32'h0000_0000);
    chk("t6_wb_count", 32'(wb_count), 32'h1);
    chk("no_dual_req", 32'(both_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
